adder_tree_accum: RTL and testbench
===================================

// Module: adder_tree_accum
// PURPOSE
//  Downstream stage of adder_tree. Consumes one reduced word per cycle, using extra_bit_out as a valid.
//  Sums ACC_LEN consecutive valid words into one wide result, i.e. a MAC/dot-product frame.
//  Presents results on a valid/ready interface through a 2-entry output buffer.
//  adder_tree cannot stall, so the input side has no backpressure; loss is flagged, never hidden.
// PARAMETERS
//  IN_BITS   29  width of in_word; equals adder_tree OUT_BITS
//  ACC_LEN   4   valid words per frame, >=1
//  ACC_BITS  31  accumulator/result width, >= IN_BITS + clog2(ACC_LEN)
//  SIGN_EXT  1   1: in_word is two's complement, sign-extended; 0: zero-extended, unsigned
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  in_word    in   IN_BITS   adder_tree out
//  in_valid   in   1         adder_tree extra_bit_out; qualifies in_word
//  clear      in   1         sync frame restart + overflow clear
//  out_data   out  ACC_BITS  frame sum at buffer head
//  out_valid  out  1         out_data valid
//  out_ready  in   1         consumer accepts when out_valid & out_ready
//  overflow   out  1         sticky: completed frame dropped (buffer full)
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): count=0, acc=0, buffer empty,
//    out_valid=0, out_data=0, overflow=0.
//  - ext(x) = in_word extended to ACC_BITS per SIGN_EXT.
//  - sum = (count==0) ? ext(in_word) : acc+ext(in_word). Arithmetic wraps mod 2^ACC_BITS.
//  - in_valid & count<ACC_LEN-1: acc<=sum, count++.
//  - in_valid & count==ACC_LEN-1: push sum into buffer, count<=0. ACC_LEN=1 pushes every valid.
//  - in_valid=0: no state change. Bubbles anywhere in a frame are allowed.
//  - Latency: push on edge N; out_data/out_valid show it after edge N if the buffer was empty.
//  - Buffer: 2-entry FIFO. out_data is registered and holds while out_valid & !out_ready.
//    out_data is 0 when empty.
//  - Push and pop in the same cycle are legal in every fill state, including full.
//  - Push when full with no pop: result discarded; overflow<=1; buffer contents untouched.
//  - clear=1: the partial frame is abandoned. clear wins over accumulation.
//    If in_valid is also 1, that word starts the new frame: acc<=ext(in_word), count<=1.
//    ACC_LEN=1 instead pushes the word.
//    overflow<=0 unless a drop occurs the same cycle, in which case it is set.
//    The buffer is NOT flushed.
//  - Reset mid-frame discards the partial frame and the buffered results.
// CONFIGURATION
//  ADDER_TREE_ACCUM_SAT_EN defined:
//    - sum saturates to the ACC_BITS range instead of wrapping.
//    - Range is signed if SIGN_EXT=1, unsigned if SIGN_EXT=0.
//    - Saturated acc stays clamped until the frame ends.
//  Not defined: pure modulo wrap, no clamp logic.
// STRUCTURE
//  - Package adder_tree_accum_pkg holds:
//    - buffer depth constant BUF_DEPTH=2;
//    - clog2 function for the count width;
//    - sat_max/sat_min functions of (ACC_BITS, SIGN_EXT).
//  - Sub-module adder_tree_accum_buf: 2-entry FIFO.
//    - Ports: push, push_data, pop, head, valid, full.
//    - Same clk/rst_n.
//  - Top keeps count, acc, sum/saturation and overflow.
// TESTING
//  - ACC_LEN=4, SIGN_EXT=1, words 5,-3,10,7 back-to-back, out_ready=1.
//    -> one out_valid pulse one cycle after 4th word; out_data=19.
//  - Same words with bubbles between each.
//    -> out_data=19; no output until 4th valid.
//  - out_ready=0, three frames of four 1s.
//    -> two results (4,4) held, overflow=1 after 3rd frame.
//    -> out_ready=1 drains 4,4, then out_valid=0.
//  - Buffer full, out_ready=1 on frame completion.
//    -> push+pop same cycle, no overflow, order preserved.
//  - clear with in_valid=1, in_word=9 after two words of a frame, then words 1,1,1.
//    -> out_data=12, overflow=0.
//  - SIGN_EXT=0, ACC_BITS=IN_BITS, four words 2^IN_BITS-1.
//    -> wraps to 2^IN_BITS-4 without macro; 2^IN_BITS-1 with ADDER_TREE_ACCUM_SAT_EN.
//  - rst_n low mid-frame with buffer holding one result.
//    -> all outputs 0 immediately; next full frame sums from zero.

Source files
------------

// File: rtl/adder_tree_accum_pkg.sv
// Shared constants and elaboration-time helpers for adder_tree_accum.
// sat_max/sat_min are only referenced when ADDER_TREE_ACCUM_SAT_EN is defined.
package adder_tree_accum_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int SAT_W     = 64;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Clamp values are returned at SAT_W bits; callers truncate to their width.
  function automatic logic [SAT_W-1:0] sat_max(input int acc_bits, input int sign_ext);
    if (sign_ext != 0) return (SAT_W'(1) << (acc_bits - 1)) - SAT_W'(1);
    return (SAT_W'(1) << acc_bits) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int acc_bits, input int sign_ext);
    if (sign_ext != 0) return ~((SAT_W'(1) << (acc_bits - 1)) - SAT_W'(1));
    return '0;
  endfunction

endpackage

// File: rtl/adder_tree_accum_buf.sv
// Two-entry output FIFO with a registered head; head reads 0 when empty.
// A push into a full buffer is ignored unless a pop happens in the same cycle.
module adder_tree_accum_buf
  import adder_tree_accum_pkg::*;
#(
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int FILL_BITS = clog2(BUF_DEPTH + 1);
  localparam logic [FILL_BITS-1:0] FILL_ONE  = FILL_BITS'(1);
  localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(BUF_DEPTH);

  logic [FILL_BITS-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]     head_q, head_d;
  logic [WIDTH-1:0]     tail_q, tail_d;
  logic                 pop_ok, push_ok;

  assign valid   = (fill_q != '0);
  assign full    = (fill_q == FILL_FULL);
  assign head    = head_q;
  assign pop_ok  = pop && valid;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    fill_d = fill_q;
    head_d = head_q;
    tail_d = tail_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (fill_q == '0) head_d = push_data;
        else              tail_d = push_data;
        fill_d = fill_q + FILL_ONE;
      end
      2'b01: begin
        head_d = (fill_q == FILL_FULL) ? tail_q : '0;
        tail_d = '0;
        fill_d = fill_q - FILL_ONE;
      end
      2'b11: begin
        if (fill_q == FILL_ONE) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the data entries are reset too, because out_data must read 0 right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
      fill_q <= fill_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: rtl/adder_tree_accum.sv
// Frame accumulator behind adder_tree: sums ACC_LEN valid words, buffers results.
// Optional build macro ADDER_TREE_ACCUM_SAT_EN: saturating sum instead of modulo wrap.
module adder_tree_accum
  import adder_tree_accum_pkg::*;
#(
  parameter int IN_BITS  = 29,
  parameter int ACC_LEN  = 4,
  parameter int ACC_BITS = 31,
  parameter int SIGN_EXT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_BITS-1:0]  in_word,
  input  logic                in_valid,
  input  logic                clear,
  output logic [ACC_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow
);

  localparam int CNT_BITS = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
  localparam logic [CNT_BITS-1:0] LAST    = CNT_BITS'(ACC_LEN - 1);
  localparam logic [ACC_BITS-1:0] HI_MASK = ~ACC_BITS'({IN_BITS{1'b1}});

  logic [CNT_BITS-1:0] count_q, count_eff;
  logic [ACC_BITS-1:0] acc_q, ext_word, base, sum;
  logic                overflow_q;
  logic                frame_start, push, pop, drop, buf_full;

  always_comb begin
    ext_word = ACC_BITS'(in_word);
    if ((SIGN_EXT != 0) && in_word[IN_BITS-1]) ext_word = ext_word | HI_MASK;
  end

  // A clear restarts the frame in the same cycle, so the incoming word is word 0.
  assign frame_start = clear || (count_q == '0);
  assign count_eff   = clear ? '0 : count_q;
  assign base        = frame_start ? '0 : acc_q;

`ifdef ADDER_TREE_ACCUM_SAT_EN
  localparam logic [ACC_BITS-1:0] SAT_MAX = ACC_BITS'(sat_max(ACC_BITS, SIGN_EXT));
  localparam logic [ACC_BITS-1:0] SAT_MIN = ACC_BITS'(sat_min(ACC_BITS, SIGN_EXT));

  logic [ACC_BITS:0] wide;
  logic              base_msb, word_msb, over_hi, over_lo;
  sat_e              sat_q, sat_next;

  assign base_msb = (SIGN_EXT != 0) && base[ACC_BITS-1];
  assign word_msb = (SIGN_EXT != 0) && ext_word[ACC_BITS-1];
  assign wide     = {base_msb, base} + {word_msb, ext_word};

  always_comb begin
    over_hi = 1'b0;
    over_lo = 1'b0;
    if (SIGN_EXT != 0) begin
      over_hi = !wide[ACC_BITS] &&  wide[ACC_BITS-1];
      over_lo =  wide[ACC_BITS] && !wide[ACC_BITS-1];
    end else begin
      over_hi = wide[ACC_BITS];
    end
  end

  // Once clamped, the frame stays clamped until it ends.
  always_comb begin
    sat_next = SAT_NONE;
    if (!frame_start && (sat_q != SAT_NONE)) sat_next = sat_q;
    else if (over_hi)                        sat_next = SAT_HI;
    else if (over_lo)                        sat_next = SAT_LO;
    case (sat_next)
      SAT_HI:  sum = SAT_MAX;
      SAT_LO:  sum = SAT_MIN;
      default: sum = wide[ACC_BITS-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sat_q <= SAT_NONE;
    else if (in_valid) sat_q <= sat_next;
  end
`else
  assign sum = base + ext_word;
`endif

  assign push = in_valid && (count_eff == LAST);
  assign pop  = out_valid && out_ready;
  assign drop = push && buf_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (in_valid)   count_q <= push ? '0 : count_eff + 1'b1;
      else if (clear) count_q <= '0;

      if (in_valid && !push) acc_q <= sum;

      if (drop)       overflow_q <= 1'b1;
      else if (clear) overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;

  adder_tree_accum_buf #(
    .WIDTH(ACC_BITS)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(sum),
    .pop      (pop),
    .head     (out_data),
    .valid    (out_valid),
    .full     (buf_full)
  );

endmodule

// File: tb/tb_adder_tree_accum.sv
// Directed, table-driven bench for adder_tree_accum (ACC_LEN=4) plus an unsigned
// ACC_BITS=IN_BITS instance whose expected result depends on ADDER_TREE_ACCUM_SAT_EN.
module tb_adder_tree_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Signed instance: IN_BITS=29, ACC_LEN=4, ACC_BITS=31, SIGN_EXT=1.
  logic [28:0] in_word;
  logic        in_valid, clear, out_ready;
  logic [30:0] out_data;
  logic        out_valid, overflow;

  // Unsigned instance: ACC_BITS equals IN_BITS, so the sum can wrap.
  logic [28:0] u_word;
  logic        u_valid, u_clear, u_ready;
  logic [28:0] u_data;
  logic        u_out_valid, u_overflow;

  adder_tree_accum #(.IN_BITS(29), .ACC_LEN(4), .ACC_BITS(31), .SIGN_EXT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .clear(clear),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow)
  );

  adder_tree_accum #(.IN_BITS(29), .ACC_LEN(4), .ACC_BITS(29), .SIGN_EXT(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_word(u_word), .in_valid(u_valid), .clear(u_clear),
    .out_data(u_data), .out_valid(u_out_valid), .out_ready(u_ready), .overflow(u_overflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic        v;
    logic [28:0] w;
    logic        c;
    logic        r;
    logic        ev;
    logic [30:0] ed;
    logic        eo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic v, input int w, input logic c,
                              input logic r, input logic ev, input int ed, input logic eo);
    vec_t x;
    x.tag = tag;
    x.v   = v;
    x.w   = 29'(w);
    x.c   = c;
    x.r   = r;
    x.ev  = ev;
    x.ed  = 31'(ed);
    x.eo  = eo;
    return x;
  endfunction

  task automatic apply(input vec_t x);
    in_valid  = x.v;
    in_word   = x.w;
    clear     = x.c;
    out_ready = x.r;
    @(posedge clk);
    #1;
    check({x.tag, " out_valid"}, 64'(out_valid), 64'(x.ev));
    check({x.tag, " out_data"},  64'(out_data),  64'(x.ed));
    check({x.tag, " overflow"},  64'(overflow),  64'(x.eo));
  endtask

  logic [28:0] u_exp;

  initial begin
    in_word = '0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    u_word  = '0; u_valid  = 1'b0; u_clear = 1'b0; u_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data",  64'(out_data),  64'd0);
    check("reset overflow",  64'(overflow),  64'd0);
    check("reset u out_valid", 64'(u_out_valid), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back frame 5,-3,10,7 -> 19.
    vecs.push_back(mk("t1 w0", 1,  5, 0, 1, 0,  0, 0));
    vecs.push_back(mk("t1 w1", 1, -3, 0, 1, 0,  0, 0));
    vecs.push_back(mk("t1 w2", 1, 10, 0, 1, 0,  0, 0));
    vecs.push_back(mk("t1 w3", 1,  7, 0, 1, 1, 19, 0));
    vecs.push_back(mk("t1 idle", 0, 0, 0, 1, 0, 0, 0));
    // Same frame with a bubble after every word.
    vecs.push_back(mk("t2 w0", 1,  5, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2 b0", 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2 w1", 1, -3, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2 b1", 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2 w2", 1, 10, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2 b2", 0,  0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t2 w3", 1,  7, 0, 1, 1, 19, 0));
    vecs.push_back(mk("t2 idle", 0, 0, 0, 1, 0, 0, 0));
    // Three frames of 1s with no consumer: two held, third dropped.
    for (int k = 1; k <= 12; k++)
      vecs.push_back(mk($sformatf("t3 w%0d", k), 1, 1, 0, 0,
                        (k >= 4), (k >= 4) ? 4 : 0, (k >= 12)));
    vecs.push_back(mk("t3 drain0", 0, 0, 0, 1, 1, 4, 1));
    vecs.push_back(mk("t3 drain1", 0, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("t3 clear",  0, 0, 1, 1, 0, 0, 0));
    // Full buffer (4, 8), third frame completes while the consumer pops.
    for (int k = 0; k < 3; k++) vecs.push_back(mk("t4 a", 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t4 a3", 1, 1, 0, 0, 1, 4, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(mk("t4 b", 1, 2, 0, 0, 1, 4, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk("t4 c", 1, 3, 0, 0, 1, 4, 0));
    vecs.push_back(mk("t4 c3 push+pop", 1, 3, 0, 1, 1, 8, 0));
    vecs.push_back(mk("t4 drain0", 0, 0, 0, 1, 1, 12, 0));
    vecs.push_back(mk("t4 drain1", 0, 0, 0, 1, 0, 0, 0));
    // Clear with a valid word restarts the frame: 9+1+1+1 = 12.
    vecs.push_back(mk("t5 w0", 1, 3, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t5 w1", 1, 4, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t5 clr9", 1, 9, 1, 1, 0, 0, 0));
    vecs.push_back(mk("t5 w2", 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t5 w3", 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t5 w4", 1, 1, 0, 1, 1, 12, 0));
    vecs.push_back(mk("t5 idle", 0, 0, 0, 1, 0, 0, 0));
    // Negative frame: sign extension into the wider accumulator.
    for (int k = 0; k < 3; k++) vecs.push_back(mk("t6 neg", 1, -1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("t6 neg3", 1, -1, 0, 1, 1, -4, 0));
    vecs.push_back(mk("t6 idle", 0, 0, 0, 1, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-frame with one result buffered.
    for (int k = 0; k < 3; k++) apply(mk("t7 fill", 1, 1, 0, 0, 0, 0, 0));
    apply(mk("t7 fill3", 1, 1, 0, 0, 1, 4, 0));
    apply(mk("t7 part0", 1, 5, 0, 0, 1, 4, 0));
    apply(mk("t7 part1", 1, 5, 0, 0, 1, 4, 0));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t7 rst out_valid", 64'(out_valid), 64'd0);
    check("t7 rst out_data",  64'(out_data),  64'd0);
    check("t7 rst overflow",  64'(overflow),  64'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) apply(mk("t7 post", 1, 2, 0, 1, 0, 0, 0));
    apply(mk("t7 post3", 1, 2, 0, 1, 1, 8, 0));
    apply(mk("t7 idle", 0, 0, 0, 1, 0, 0, 0));

    // Unsigned, ACC_BITS=IN_BITS: four all-ones words.
`ifdef ADDER_TREE_ACCUM_SAT_EN
    u_exp = 29'h1FFF_FFFF;
`else
    u_exp = 29'h1FFF_FFFC;
`endif
    u_word  = 29'h1FFF_FFFF;
    u_valid = 1'b1;
    u_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t8 u out_valid w%0d", k), 64'(u_out_valid), 64'(k == 3));
    end
    check("t8 u out_data", 64'(u_data), 64'(u_exp));
    check("t8 u overflow", 64'(u_overflow), 64'd0);
    u_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t8 u idle out_valid", 64'(u_out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
